t03_wishbone_burst_manager: RTL

Parametrised Wishbone classic bus manager: the next generation of the team's single-beat manager. It accepts one request at a time from the cache/CPU side through a ready/valid handshake and runs 1..MAX_BURST beat incrementing bursts. CYC_O is held across the whole burst. The block adds bus-error termination and an optional watchdog timeout, and sits between the cache controller and the Wishbone interconnect.

---
 rtl/t03_wbm_pkg.sv | 19 +
 rtl/t03_wbm_timeout_counter.sv | 37 +++
 rtl/t03_wishbone_burst_manager.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/t03_wbm_pkg.sv
// Shared definitions for the t03 Wishbone burst manager: default parameter
// values and the controller state encoding.
// Optional feature macro: T03_WBM_TIMEOUT_EN (bus watchdog timeout).
package t03_wbm_pkg;

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_MAX_BURST   = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 255;

    // Controller states: IDLE (ready for a request), BUS (cycle open,
    // waiting for the slave), RESP (one-cycle completion report).
    typedef logic [1:0] wbm_state_t;

    localparam wbm_state_t ST_IDLE = 2'd0;
    localparam wbm_state_t ST_BUS  = 2'd1;
    localparam wbm_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/t03_wbm_timeout_counter.sv
// Watchdog for the burst manager: counts consecutive bus cycles in which
// the slave gave no response. 'expired' flags the cycle that is the
// TIMEOUT_CYC-th silent one, so the abort edge closes that cycle.
// Only instantiated when T03_WBM_TIMEOUT_EN is defined.
module t03_wbm_timeout_counter
    import t03_wbm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_r;

    assign expired = enable && (cnt_r == LAST_C);

    // Silent-cycle counter: restarts on clear, advances while enabled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/t03_wishbone_burst_manager.sv
// Wishbone classic burst manager. Takes one request at a time from the
// cache/CPU side and runs an incrementing burst of 1..MAX_BURST beats with
// CYC_O held for the whole burst. ERR_I (or the optional watchdog) aborts.
// Optional feature macro: T03_WBM_TIMEOUT_EN (watchdog, sets TMO_O).
module t03_wishbone_burst_manager
    import t03_wbm_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned MAX_BURST   = DEF_MAX_BURST,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          REQ_I,
    output logic                          REQ_RDY_O,
    input  logic                          WRITE_I,
    input  logic [ADDR_W-1:0]             ADR_I,
    input  logic [DATA_W/8-1:0]           SEL_I,
    input  logic [$clog2(MAX_BURST)-1:0]  LEN_I,
    input  logic [DATA_W-1:0]             CPU_DAT_I,
    output logic [DATA_W-1:0]             CPU_DAT_O,
    output logic                          RVALID_O,
    output logic                          WNEXT_O,
    output logic                          DONE_O,
    output logic                          ERR_O,
    output logic                          TMO_O,
    output logic                          BUSY_O,
    output logic [ADDR_W-1:0]             ADR_O,
    output logic [DATA_W-1:0]             DAT_O,
    output logic [DATA_W/8-1:0]           SEL_O,
    output logic                          WE_O,
    output logic                          STB_O,
    output logic                          CYC_O,
    input  logic [DATA_W-1:0]             DAT_I,
    input  logic                          ACK_I,
    input  logic                          ERR_I
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned LEN_W = $clog2(MAX_BURST);
    // Byte distance between consecutive beats; the adder wraps at 2^ADDR_W.
    localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(SEL_W);

    wbm_state_t        state_r;
    logic [LEN_W-1:0]  beat_r;
    logic [LEN_W-1:0]  len_r;
    logic              we_r;
    logic              cyc_r;
    logic              stb_r;
    logic [ADDR_W-1:0] adr_r;
    logic [DATA_W-1:0] dat_r;
    logic [SEL_W-1:0]  sel_r;
    logic [DATA_W-1:0] cpu_dat_r;
    logic              rvalid_r;
    logic              wnext_r;
    logic              done_r;
    logic              err_r;
    logic              tmo_r;
    logic              busy_r;

    logic              accept_s;
    logic              in_bus_s;
    logic              ack_s;
    logic              tmo_s;

    assign accept_s = (state_r == ST_IDLE) && REQ_I;
    assign in_bus_s = (state_r == ST_BUS);
    assign ack_s    = in_bus_s && ACK_I && !ERR_I;

`ifdef T03_WBM_TIMEOUT_EN
    logic silent_s;

    assign silent_s = in_bus_s && !ACK_I && !ERR_I;

    t03_wbm_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (accept_s || ack_s),
        .enable  (silent_s),
        .expired (tmo_s)
    );
`else
    // Without the watchdog the manager waits for ACK_I/ERR_I indefinitely.
    assign tmo_s = 1'b0;
`endif

    // Burst controller: sequences IDLE/BUS/RESP and registers every output.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= ST_IDLE;
            beat_r    <= '0;
            len_r     <= '0;
            we_r      <= 1'b0;
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            adr_r     <= '0;
            dat_r     <= '0;
            sel_r     <= '0;
            cpu_dat_r <= '0;
            rvalid_r  <= 1'b0;
            wnext_r   <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            tmo_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            rvalid_r <= 1'b0;
            wnext_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    tmo_r  <= 1'b0;
                    if (accept_s) begin
                        state_r <= ST_BUS;
                        beat_r  <= '0;
                        len_r   <= LEN_I;
                        we_r    <= WRITE_I;
                        cyc_r   <= 1'b1;
                        stb_r   <= 1'b1;
                        adr_r   <= ADR_I;
                        sel_r   <= SEL_I;
                        dat_r   <= WRITE_I ? CPU_DAT_I : '0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    if (ERR_I || tmo_s) begin
                        // Abort: ERR_I wins over a simultaneous ACK_I and
                        // the interrupted beat is not reported upstream.
                        state_r <= ST_RESP;
                        cyc_r   <= 1'b0;
                        stb_r   <= 1'b0;
                        we_r    <= 1'b0;
                        adr_r   <= '0;
                        dat_r   <= '0;
                        sel_r   <= '0;
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                        tmo_r   <= tmo_s && !ERR_I;
                    end else if (ACK_I) begin
                        if (!we_r) begin
                            cpu_dat_r <= DAT_I;
                        end else begin
                            cpu_dat_r <= cpu_dat_r;
                        end
                        rvalid_r <= !we_r;
                        wnext_r  <= we_r;
                        if (beat_r == len_r) begin
                            state_r <= ST_RESP;
                            cyc_r   <= 1'b0;
                            stb_r   <= 1'b0;
                            we_r    <= 1'b0;
                            adr_r   <= '0;
                            dat_r   <= '0;
                            sel_r   <= '0;
                            done_r  <= 1'b1;
                            err_r   <= 1'b0;
                            tmo_r   <= 1'b0;
                        end else begin
                            beat_r <= beat_r + LEN_W'(1);
                            adr_r  <= adr_r + STRIDE_C;
                            dat_r  <= we_r ? CPU_DAT_I : '0;
                        end
                    end else begin
                        // Waiting on the slave: keep write data tracking the CPU.
                        dat_r <= we_r ? CPU_DAT_I : '0;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    tmo_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cyc_r   <= 1'b0;
                    stb_r   <= 1'b0;
                    we_r    <= 1'b0;
                    adr_r   <= '0;
                    dat_r   <= '0;
                    sel_r   <= '0;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                    tmo_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign REQ_RDY_O = (state_r == ST_IDLE);
    assign CPU_DAT_O = cpu_dat_r;
    assign RVALID_O  = rvalid_r;
    assign WNEXT_O   = wnext_r;
    assign DONE_O    = done_r;
    assign ERR_O     = err_r;
    assign TMO_O     = tmo_r;
    assign BUSY_O    = busy_r;
    assign ADR_O     = adr_r;
    assign DAT_O     = dat_r;
    assign SEL_O     = sel_r;
    assign WE_O      = we_r;
    assign STB_O     = stb_r;
    assign CYC_O     = cyc_r;

endmodule
